// File: rtl/mips_pkg.sv
// Shared MIPS control constants: opcodes, datapath select encodings, multicycle FSM states
// and the control word driven by the main decoder.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StRtypeWb = 4'd7,
    StBeqEx   = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJEx     = 4'd11
  } state_e;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_supported(logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_maindec_if.sv
// Main-decoder bundle: instruction opcode and memory ready in, datapath control word out.
interface mc_maindec_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite;
  logic       branch;
  logic       irwrite;
  logic       memwrite;
  logic       regwrite;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [1:0] aluop;
  logic       illegal_op;
  logic [3:0] state_dbg;

  modport master (
    output op, mem_ready,
    input  pcwrite, branch, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca,
    input  alusrcb, pcsrc, aluop, illegal_op, state_dbg
  );

  modport slave (
    input  op, mem_ready,
    output pcwrite, branch, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca,
    output alusrcb, pcsrc, aluop, illegal_op, state_dbg
  );
endinterface

// File: rtl/mc_outdec.sv
// Combinational state -> control-word table for the multicycle main decoder.
module mc_outdec
  import mips_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] op_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      StFetch: begin
        ctrl_o.alusrcb = SRCB_FOUR;
        ctrl_o.aluop   = ALUOP_ADD;
        ctrl_o.pcsrc   = PCSRC_ALU;
        // PC+4 and IR load only on the cycle memory actually returns the instruction
        ctrl_o.irwrite = mem_ready_i;
        ctrl_o.pcwrite = mem_ready_i;
      end
      StDecode: begin
        ctrl_o.alusrcb    = SRCB_IMMSH;
        ctrl_o.aluop      = ALUOP_ADD;
        ctrl_o.illegal_op = !op_supported(op_i);
      end
      StMemAdr, StAddiEx: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      StMemRd: ctrl_o.iord = 1'b1;
      StMemWb: begin
        ctrl_o.memtoreg = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      StMemWr: begin
        ctrl_o.iord     = 1'b1;
        ctrl_o.memwrite = 1'b1;
      end
      StRtypeEx: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_REG;
        ctrl_o.aluop   = ALUOP_FUNCT;
      end
      StRtypeWb: begin
        ctrl_o.regdst   = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      StBeqEx: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_REG;
        ctrl_o.aluop   = ALUOP_SUB;
        ctrl_o.pcsrc   = PCSRC_ALUOUT;
        ctrl_o.branch  = 1'b1;
      end
      StAddiWb: ctrl_o.regwrite = 1'b1;
      StJEx: begin
        ctrl_o.pcsrc   = PCSRC_JUMP;
        ctrl_o.pcwrite = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mc_maindec.sv
// Multicycle MIPS main decoder: state register and next-state logic; outputs come from mc_outdec.
module mc_maindec
  import mips_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  mc_maindec_if.slave  bus
);

  state_e state_q, state_d;
  state_e dec_state;
  logic   ready;
  ctrl_t  ctrl, ctrl_out;

  assign ready = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (ready) state_d = StDecode;
      StDecode: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_RTYPE:     state_d = StRtypeEx;
          OP_BEQ:       state_d = StBeqEx;
          OP_ADDI:      state_d = StAddiEx;
          OP_J:         state_d = StJEx;
          default:      state_d = StFetch;
        endcase
      end
      StMemAdr:  state_d = (bus.op == OP_LW) ? StMemRd : StMemWr;
      StMemRd:   if (ready) state_d = StMemWb;
      StMemWr:   if (ready) state_d = StFetch;
      StRtypeEx: state_d = StRtypeWb;
      StAddiEx:  state_d = StAddiWb;
      StMemWb, StRtypeWb, StBeqEx, StAddiWb, StJEx: state_d = StFetch;
      default:   state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  // During reset the selects show FETCH values even before the first reset edge lands
  assign dec_state = reset ? StFetch : state_q;

  mc_outdec u_outdec (
    .state_i     (dec_state),
    .op_i        (bus.op),
    .mem_ready_i (ready),
    .ctrl_o      (ctrl)
  );

  always_comb begin
    ctrl_out = ctrl;
    if (reset) begin
      ctrl_out.pcwrite    = 1'b0;
      ctrl_out.branch     = 1'b0;
      ctrl_out.irwrite    = 1'b0;
      ctrl_out.memwrite   = 1'b0;
      ctrl_out.regwrite   = 1'b0;
      ctrl_out.illegal_op = 1'b0;
    end
  end

  assign bus.pcwrite    = ctrl_out.pcwrite;
  assign bus.branch     = ctrl_out.branch;
  assign bus.irwrite    = ctrl_out.irwrite;
  assign bus.memwrite   = ctrl_out.memwrite;
  assign bus.regwrite   = ctrl_out.regwrite;
  assign bus.iord       = ctrl_out.iord;
  assign bus.memtoreg   = ctrl_out.memtoreg;
  assign bus.regdst     = ctrl_out.regdst;
  assign bus.alusrca    = ctrl_out.alusrca;
  assign bus.alusrcb    = ctrl_out.alusrcb;
  assign bus.pcsrc      = ctrl_out.pcsrc;
  assign bus.aluop      = ctrl_out.aluop;
  assign bus.illegal_op = ctrl_out.illegal_op;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_mc_maindec.sv
// Scoreboard bench for mc_maindec: directed per-cycle vectors push expected state/control words,
// a negedge monitor pops and compares against the handshaking and non-handshaking instances.
module tb_mc_maindec;
  import mips_pkg::*;

  // Word layout: {pcwrite,branch,irwrite,memwrite,regwrite}, {iord,memtoreg,regdst,alusrca},
  // alusrcb, pcsrc, aluop, illegal_op
  localparam logic [15:0] W_RST    = {5'b00000, 4'b0000, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] W_FETCH  = {5'b10100, 4'b0000, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] W_STALL  = {5'b00000, 4'b0000, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] W_DEC    = {5'b00000, 4'b0000, 2'b11, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] W_DECILL = {5'b00000, 4'b0000, 2'b11, 2'b00, 2'b00, 1'b1};
  localparam logic [15:0] W_MEMADR = {5'b00000, 4'b0001, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] W_MEMRD  = {5'b00000, 4'b1000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] W_MEMWB  = {5'b00001, 4'b0100, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] W_MEMWR  = {5'b00010, 4'b1000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] W_RTEX   = {5'b00000, 4'b0001, 2'b00, 2'b00, 2'b10, 1'b0};
  localparam logic [15:0] W_RTWB   = {5'b00001, 4'b0010, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] W_BEQ    = {5'b01000, 4'b0001, 2'b00, 2'b01, 2'b01, 1'b0};
  localparam logic [15:0] W_ADDIEX = {5'b00000, 4'b0001, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] W_ADDIWB = {5'b00001, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] W_JEX    = {5'b10000, 4'b0000, 2'b00, 2'b10, 2'b00, 1'b0};

  localparam logic [5:0] OP_BAD = 6'b111111;

  typedef struct {
    int          d;
    logic [3:0]  st;
    logic [15:0] w;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst1, rst2;
  exp_t sbq[$];
  exp_t mon_e;
  logic [15:0] act_w;
  logic [3:0]  act_s;
  int checks = 0;
  int failures = 0;

  mc_maindec_if b1 ();
  mc_maindec_if b2 ();

  mc_maindec #(.MEM_HANDSHAKE(1'b1)) u_dut1 (.clk(clk), .reset(rst1), .bus(b1));
  mc_maindec #(.MEM_HANDSHAKE(1'b0)) u_dut2 (.clk(clk), .reset(rst2), .bus(b2));

  always #5 clk = ~clk;

  function automatic logic [15:0] word_of(input int d);
    if (d == 0)
      return {b1.pcwrite, b1.branch, b1.irwrite, b1.memwrite, b1.regwrite, b1.iord, b1.memtoreg,
              b1.regdst, b1.alusrca, b1.alusrcb, b1.pcsrc, b1.aluop, b1.illegal_op};
    return {b2.pcwrite, b2.branch, b2.irwrite, b2.memwrite, b2.regwrite, b2.iord, b2.memtoreg,
            b2.regdst, b2.alusrca, b2.alusrcb, b2.pcsrc, b2.aluop, b2.illegal_op};
  endfunction

  // Drive one cycle's inputs just after the edge and record what that cycle must show
  task automatic cyc(input int d, input logic r, input logic [5:0] o, input logic mr,
                     input logic [3:0] st, input logic [15:0] w, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (d == 0) begin
      rst1 = r;
      b1.op = o;
      b1.mem_ready = mr;
    end else begin
      rst2 = r;
      b2.op = o;
    end
    e.d = d;
    e.st = st;
    e.w = w;
    e.tag = tag;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      act_w = word_of(mon_e.d);
      act_s = (mon_e.d == 0) ? b1.state_dbg : b2.state_dbg;
      checks += 2;
      if (act_s !== mon_e.st) begin
        failures++;
        $display("FAIL %s state_dbg: got %0d want %0d", mon_e.tag, act_s, mon_e.st);
      end
      if (act_w !== mon_e.w) begin
        failures++;
        $display("FAIL %s ctrl: got %b want %b", mon_e.tag, act_w, mon_e.w);
      end
    end
  end

  initial begin
    rst1 = 1'b1;
    rst2 = 1'b1;
    b1.op = OP_RTYPE;
    b1.mem_ready = 1'b1;
    b2.op = OP_LW;
    b2.mem_ready = 1'b0;

    // Reset for two cycles, then R-type
    cyc(0, 1'b1, OP_RTYPE, 1'b1, 4'd0, W_RST, "rst_a");
    cyc(0, 1'b1, OP_RTYPE, 1'b1, 4'd0, W_RST, "rst_b");
    cyc(0, 1'b0, OP_RTYPE, 1'b1, 4'd0, W_FETCH, "rt_fetch");
    cyc(0, 1'b0, OP_RTYPE, 1'b1, 4'd1, W_DEC, "rt_dec");
    cyc(0, 1'b0, OP_RTYPE, 1'b1, 4'd6, W_RTEX, "rt_ex");
    cyc(0, 1'b0, OP_RTYPE, 1'b1, 4'd7, W_RTWB, "rt_wb");

    // LW with three wait states in MEMRD
    cyc(0, 1'b0, OP_LW, 1'b1, 4'd0, W_FETCH, "lw_fetch");
    cyc(0, 1'b0, OP_LW, 1'b1, 4'd1, W_DEC, "lw_dec");
    cyc(0, 1'b0, OP_LW, 1'b1, 4'd2, W_MEMADR, "lw_adr");
    for (int i = 0; i < 3; i++) cyc(0, 1'b0, OP_LW, 1'b0, 4'd3, W_MEMRD, "lw_rd_wait");
    cyc(0, 1'b0, OP_LW, 1'b1, 4'd3, W_MEMRD, "lw_rd_ready");
    cyc(0, 1'b0, OP_LW, 1'b1, 4'd4, W_MEMWB, "lw_wb");

    // SW with fetch stall and write stall
    cyc(0, 1'b0, OP_SW, 1'b0, 4'd0, W_STALL, "sw_fetch_wait1");
    cyc(0, 1'b0, OP_SW, 1'b0, 4'd0, W_STALL, "sw_fetch_wait2");
    cyc(0, 1'b0, OP_SW, 1'b1, 4'd0, W_FETCH, "sw_fetch_ready");
    cyc(0, 1'b0, OP_SW, 1'b1, 4'd1, W_DEC, "sw_dec");
    cyc(0, 1'b0, OP_SW, 1'b1, 4'd2, W_MEMADR, "sw_adr");
    cyc(0, 1'b0, OP_SW, 1'b0, 4'd5, W_MEMWR, "sw_wr_wait1");
    cyc(0, 1'b0, OP_SW, 1'b0, 4'd5, W_MEMWR, "sw_wr_wait2");
    cyc(0, 1'b0, OP_SW, 1'b1, 4'd5, W_MEMWR, "sw_wr_ready");

    // BEQ, J, ADDI
    cyc(0, 1'b0, OP_BEQ, 1'b1, 4'd0, W_FETCH, "beq_fetch");
    cyc(0, 1'b0, OP_BEQ, 1'b1, 4'd1, W_DEC, "beq_dec");
    cyc(0, 1'b0, OP_BEQ, 1'b1, 4'd8, W_BEQ, "beq_ex");
    cyc(0, 1'b0, OP_J, 1'b1, 4'd0, W_FETCH, "j_fetch");
    cyc(0, 1'b0, OP_J, 1'b1, 4'd1, W_DEC, "j_dec");
    cyc(0, 1'b0, OP_J, 1'b1, 4'd11, W_JEX, "j_ex");
    cyc(0, 1'b0, OP_ADDI, 1'b1, 4'd0, W_FETCH, "addi_fetch");
    cyc(0, 1'b0, OP_ADDI, 1'b1, 4'd1, W_DEC, "addi_dec");
    cyc(0, 1'b0, OP_ADDI, 1'b1, 4'd9, W_ADDIEX, "addi_ex");
    cyc(0, 1'b0, OP_ADDI, 1'b1, 4'd10, W_ADDIWB, "addi_wb");

    // Illegal opcode: one-cycle pulse, straight back to FETCH
    cyc(0, 1'b0, OP_BAD, 1'b1, 4'd0, W_FETCH, "ill_fetch");
    cyc(0, 1'b0, OP_BAD, 1'b1, 4'd1, W_DECILL, "ill_dec");
    cyc(0, 1'b0, OP_BAD, 1'b0, 4'd0, W_STALL, "ill_after");

    // Reset mid-write kills memwrite immediately
    cyc(0, 1'b0, OP_SW, 1'b1, 4'd0, W_FETCH, "rw_fetch");
    cyc(0, 1'b0, OP_SW, 1'b1, 4'd1, W_DEC, "rw_dec");
    cyc(0, 1'b0, OP_SW, 1'b1, 4'd2, W_MEMADR, "rw_adr");
    cyc(0, 1'b0, OP_SW, 1'b0, 4'd5, W_MEMWR, "rw_wr_wait");
    cyc(0, 1'b1, OP_SW, 1'b0, 4'd5, W_RST, "rw_reset");
    cyc(0, 1'b0, OP_SW, 1'b0, 4'd0, W_STALL, "rw_after");

    // No-handshake instance: mem_ready held 0, LW still takes 5 cycles
    cyc(1, 1'b1, OP_LW, 1'b0, 4'd0, W_RST, "nh_rst");
    cyc(1, 1'b0, OP_LW, 1'b0, 4'd0, W_FETCH, "nh_fetch");
    cyc(1, 1'b0, OP_LW, 1'b0, 4'd1, W_DEC, "nh_dec");
    cyc(1, 1'b0, OP_LW, 1'b0, 4'd2, W_MEMADR, "nh_adr");
    cyc(1, 1'b0, OP_LW, 1'b0, 4'd3, W_MEMRD, "nh_rd");
    cyc(1, 1'b0, OP_LW, 1'b0, 4'd4, W_MEMWB, "nh_wb");
    cyc(1, 1'b0, OP_LW, 1'b0, 4'd0, W_FETCH, "nh_next_fetch");

    for (int i = 0; i < 8 && sbq.size() != 0; i++) @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d entries left, want 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
